pipeline_skid_stage: RTL and testbench

PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

---
 rtl/pipeline_pkg.sv | 10 +
 rtl/pipeline_stage_cell.sv | 30 +++
 rtl/pipeline_skid_stage.sv | 88 ++++++++
 tb/tb_pipeline_skid_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: parameter limits and occupancy-width helper shared by the skid pipeline
package pipeline_pkg;
    localparam int N_MIN = 1;
    localparam int N_MAX = 128;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 8;
    function automatic int occ_w(input int depth);
        return $clog2(depth + 2);
    endfunction
endpackage

// File: rtl/pipeline_stage_cell.sv
// pipeline_stage_cell: one {valid, data} register with load, hold and clear controls
module pipeline_stage_cell #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic         valid_i,
    input  logic [N-1:0] data_i,
    output logic         valid_o,
    output logic [N-1:0] data_o
);
    logic         valid_q;
    logic [N-1:0] data_q;
    // clear drops only the valid bit so the data lines do not toggle
    always_ff @(negedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= valid_i;
            if (valid_i) data_q <= data_i;
        end
    end
    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipeline_skid_stage.sv
// pipeline_skid_stage: DEPTH-stage valid/ready pipeline with a skid entry and registered in_ready
module pipeline_skid_stage
    import pipeline_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [N-1:0]              in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [N-1:0]              out_data,
    input  logic                      out_ready,
    output logic [occ_w(DEPTH)-1:0]   occupancy
);
    localparam int OW = occ_w(DEPTH);
    logic [DEPTH-1:0] sv;
    logic [N-1:0]     sd [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             skid_valid, skid_next, in_fire, out_fire;
    logic [N-1:0]     skid_data;
    logic             in_ready_q, in_ready_d;
    logic [OW-1:0]    occ_q, occ_d;

    assign out_valid = sv[DEPTH-1] & ~flush;
    assign out_data  = sd[DEPTH-1];
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready_q & ~flush;

    // a stage advances when any stage at or after it is empty, or the consumer takes the head
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        assign adv[g] = out_ready | ~&sv[DEPTH-1:g];
        if (g == 0) begin : g_head
            pipeline_stage_cell #(.N(N)) u_cell (
                .clk, .reset,
                .load_i (adv[0]),
                .clear_i(flush),
                .valid_i(skid_valid | in_fire),
                .data_i (skid_valid ? skid_data : in_data),
                .valid_o(sv[0]),
                .data_o (sd[0])
            );
        end else begin : g_body
            pipeline_stage_cell #(.N(N)) u_cell (
                .clk, .reset,
                .load_i (adv[g]),
                .clear_i(flush),
                .valid_i(sv[g-1]),
                .data_i (sd[g-1]),
                .valid_o(sv[g]),
                .data_o (sd[g])
            );
        end
    end

    // skid drains into stage 0 when it advances, otherwise catches a transfer stage 0 cannot take
    pipeline_stage_cell #(.N(N)) u_skid (
        .clk, .reset,
        .load_i (adv[0] ? skid_valid : in_fire),
        .clear_i(flush),
        .valid_i(~skid_valid),
        .data_i (in_data),
        .valid_o(skid_valid),
        .data_o (skid_data)
    );

    always_comb begin
        skid_next  = ~flush & ~adv[0] & (skid_valid | in_fire);
        in_ready_d = ~flush & ~skid_next;
        occ_d      = flush ? '0 : occ_q + OW'(in_fire) - OW'(out_fire);
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            in_ready_q <= 1'b0;
            occ_q      <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            occ_q      <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = occ_q;
endmodule

// File: tb/tb_pipeline_skid_stage.sv
// tb_pipeline_skid_stage: DEPTH 2/1/8 instances checked against a queue-based transfer model
module tb_pipeline_skid_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [2:0] iv = '0;
    logic [2:0] ordy = '1;
    logic [2:0] ir, ov;
    logic [31:0] id [3];
    logic [31:0] od [3];
    logic [1:0] occ_a, occ_b;
    logic [3:0] occ_c;
    int occ [3];
    int dep [3] = '{2, 1, 8};
    logic [31:0] qd [3][$];
    int qt [3][$];
    bit rdy_ok [3];
    int n = 0;
    int passed = 0;
    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        occ[0] = int'(occ_a);
        occ[1] = int'(occ_b);
        occ[2] = int'(occ_c);
    end

    pipeline_skid_stage #(.N(32), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[0]), .in_data(id[0]),
        .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]), .occupancy(occ_a));
    pipeline_skid_stage #(.N(32), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[1]), .in_data(id[1]),
        .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]), .occupancy(occ_b));
    pipeline_skid_stage #(.N(32), .DEPTH(8)) u_d8 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[2]), .in_data(id[2]),
        .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]), .out_ready(ordy[2]), .occupancy(occ_c));

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, i, obs, exp);
        end
    endtask

    // the head entry is never blocked, so it reaches the last stage DEPTH-1 edges after entering
    function automatic logic exp_ov(input int i);
        if (flush || qd[i].size() == 0) return 1'b0;
        return (n - 1 - qt[i][0]) >= dep[i] - 1;
    endfunction

    function automatic logic exp_ir(input int i);
        return rdy_ok[i] && qd[i].size() <= dep[i];
    endfunction

    task automatic check_all();
        logic e;
        for (int i = 0; i < 3; i++) begin
            e = exp_ov(i);
            chk("in_ready", i, {31'b0, ir[i]}, {31'b0, exp_ir(i)});
            chk("out_valid", i, {31'b0, ov[i]}, {31'b0, e});
            if (e) chk("out_data", i, od[i], qd[i][0]);
            chk("occupancy", i, 32'(occ[i]), 32'(qd[i].size()));
        end
    endtask

    task automatic update();
        logic ofire, ifire;
        for (int i = 0; i < 3; i++) begin
            if (!reset || flush) begin
                qd[i].delete();
                qt[i].delete();
                rdy_ok[i] = 1'b0;
            end else begin
                ofire = exp_ov(i) && ordy[i];
                ifire = iv[i] && exp_ir(i);
                if (ofire) begin
                    void'(qd[i].pop_front());
                    void'(qt[i].pop_front());
                end
                if (ifire) begin
                    qd[i].push_back(id[i]);
                    qt[i].push_back(n);
                end
                rdy_ok[i] = 1'b1;
            end
        end
        n++;
    endtask

    task automatic step();
        #1 check_all();
        @(negedge clk);
        update();
        @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) id[i] = '0;
        repeat (2) begin
            @(negedge clk);
            update();
        end
        @(posedge clk);
        reset = 1'b1;
        step();
        // scenario 1: streaming with out_ready high
        for (int k = 1; k <= 4; k++) begin
            iv[0] = 1'b1;
            id[0] = 32'hA5A5_0000 + 32'(k);
            step();
        end
        #1 chk("s1_ov", 0, {31'b0, ov[0]}, 32'd1);
        chk("s1_data", 0, od[0], 32'hA5A5_0003);
        iv[0] = 1'b0;
        repeat (3) step();
        // scenario 2: back-pressure fills two stages plus skid
        ordy[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv[0] = 1'b1;
            id[0] = 32'hB000_0000 + 32'(k);
            step();
        end
        #1 chk("s2_occ", 0, 32'(occ[0]), 32'd3);
        chk("s2_ready", 0, {31'b0, ir[0]}, 32'd0);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        repeat (3) step();
        #1 chk("s2_ready_back", 0, {31'b0, ir[0]}, 32'd1);
        chk("s2_occ_empty", 0, 32'(occ[0]), 32'd0);
        // scenario 3: flush a full pipe with a pending 0xDEADBEEF
        ordy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[0] = 1'b1;
            id[0] = 32'hC000_0000 + 32'(k);
            step();
        end
        id[0] = 32'hDEAD_BEEF;
        step();
        flush = 1'b1;
        #1 chk("s3_flush_ov", 0, {31'b0, ov[0]}, 32'd0);
        step();
        flush = 1'b0;
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        #1 chk("s3_occ", 0, 32'(occ[0]), 32'd0);
        repeat (3) step();
        // scenario 4: reset mid-stream with two entries held
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        id[0] = 32'hD000_0001;
        step();
        id[0] = 32'hD000_0002;
        step();
        #1 chk("s4_occ_pre", 0, 32'(occ[0]), 32'd2);
        reset = 1'b0;
        flush = 1'b1;
        ordy[0] = 1'b1;
        step();
        #1 chk("s4_occ", 0, 32'(occ[0]), 32'd0);
        chk("s4_ov", 0, {31'b0, ov[0]}, 32'd0);
        chk("s4_data", 0, od[0], 32'd0);
        chk("s4_ready", 0, {31'b0, ir[0]}, 32'd0);
        reset = 1'b1;
        flush = 1'b0;
        iv[0] = 1'b0;
        step();
        #1 chk("s4_ready_rel", 0, {31'b0, ir[0]}, 32'd1);
        // scenario 5: random valid/ready on all three depths
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i] = 1'($urandom_range(0, 1));
                ordy[i] = 1'($urandom_range(0, 1));
                id[i] = $urandom;
            end
            step();
        end
        iv = '0;
        ordy = '1;
        repeat (12) step();
        for (int i = 0; i < 3; i++) chk("drained", i, 32'(occ[i]), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
